// File: rtl/full_adder_t4_trojan_pkg.sv
// Shared definitions for the trojan-instrumented full adder: FSM encodings,
// default LFSR seed/taps and a counter-width helper.
package full_adder_t4_trojan_pkg;

    typedef enum logic [1:0] {
        FA_T_IDLE   = 2'd0,
        FA_T_ARMING = 2'd1,
        FA_T_ACTIVE = 2'd2
    } fa_t_state_e;

    localparam logic [15:0] FA_T_DEF_SEED = 16'hACE1;
    localparam logic [15:0] FA_T_DEF_TAPS = 16'hB400;

    // Bits needed to hold 0..n, never less than one.
    function automatic int fa_t_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/full_adder_t4_trojan_lfsr.sv
// 16-bit Galois right-shift LFSR with synchronous reload; resets to seed.
module lfsr_galois16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic [15:0] taps,
    output logic [15:0] q
);

    logic [15:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = seed;
        else if (en)
            q_d = (q_q >> 1) ^ (q_q[0] ? taps : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= seed;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/full_adder_t4_trojan.sv
// Registered full adder with a rare-trigger activity payload (free-running LFSR).
// The payload only burns switching power; sum/cout are never affected.
module full_adder_t4_trojan
    import full_adder_t4_trojan_pkg::*;
#(
    parameter int          TRIG_LEN      = 6,
    parameter logic [15:0] SEED          = FA_T_DEF_SEED,
    parameter logic [15:0] LFSR_TAPS     = FA_T_DEF_TAPS,
    parameter int          ACTIVE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout,
    output logic trojan_active
);

    // An all-zero seed would lock the LFSR, so it is replaced at elaboration.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int          TW       = fa_t_cnt_w(TRIG_LEN);
    localparam int          DW       = fa_t_cnt_w(ACTIVE_CYCLES);
    localparam logic [TW-1:0] TRIG_MAX = TW'(TRIG_LEN);
    localparam logic [DW-1:0] DUR_MAX  = DW'(ACTIVE_CYCLES);

    fa_t_state_e   state_q, state_d;
    logic [TW-1:0] trig_cnt_q, trig_cnt_d;
    logic [DW-1:0] dur_q, dur_d;
    logic          sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          lfsr_en, lfsr_load;
    logic          trig;
    logic [15:0]   trojan_shift_reg;

    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        dur_d      = dur_q;
        lfsr_en    = 1'b0;
        lfsr_load  = 1'b0;
        trig       = a & b & cin;
        sum_d      = a ^ b ^ cin;
        cout_d     = (a & b) | (a & cin) | (b & cin);

        case (state_q)
            FA_T_ACTIVE: begin
                // Inputs are ignored here; only the duration limit leaves ACTIVE.
                if ((ACTIVE_CYCLES > 0) && (dur_q == DUR_MAX)) begin
                    state_d    = FA_T_IDLE;
                    trig_cnt_d = '0;
                    dur_d      = '0;
                    lfsr_load  = 1'b1;
                end else begin
                    lfsr_en = 1'b1;
                    if (ACTIVE_CYCLES > 0)
                        dur_d = dur_q + 1'b1;
                end
            end
            default: begin
                if ((TRIG_LEN == 0) || !trig) begin
                    state_d    = FA_T_IDLE;
                    trig_cnt_d = '0;
                end else begin
                    if (trig_cnt_q != TRIG_MAX)
                        trig_cnt_d = trig_cnt_q + 1'b1;
                    state_d = (trig_cnt_d >= TRIG_MAX) ? FA_T_ACTIVE : FA_T_ARMING;
                    dur_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FA_T_IDLE;
            trig_cnt_q <= '0;
            dur_q      <= '0;
            sum_q      <= 1'b0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_cnt_q <= trig_cnt_d;
            dur_q      <= dur_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
        end
    end

    lfsr_galois16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .load  (lfsr_load),
        .seed  (SEED_EFF),
        .taps  (LFSR_TAPS),
        .q     (trojan_shift_reg)
    );

    assign sum           = sum_q;
    assign cout          = cout_q;
    assign trojan_active = (state_q == FA_T_ACTIVE);

endmodule

// File: tb/tb_full_adder_t4_trojan.sv
// Bench for full_adder_t4_trojan: three configurations (default, 10-cycle payload,
// payload disabled) share one stimulus stream and are checked against a model.
module tb_full_adder_t4_trojan;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam int TL [3] = '{6, 6, 0};
    localparam int AC [3] = '{0, 10, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0, b = 1'b0, cin = 1'b0;
    logic sum_o [3];
    logic cout_o [3];
    logic act_o [3];
    logic [15:0] pr [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    full_adder_t4_trojan #(.TRIG_LEN(6), .ACTIVE_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
        .sum(sum_o[0]), .cout(cout_o[0]), .trojan_active(act_o[0]));
    full_adder_t4_trojan #(.TRIG_LEN(6), .ACTIVE_CYCLES(10)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
        .sum(sum_o[1]), .cout(cout_o[1]), .trojan_active(act_o[1]));
    full_adder_t4_trojan #(.TRIG_LEN(0), .ACTIVE_CYCLES(0)) u2 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
        .sum(sum_o[2]), .cout(cout_o[2]), .trojan_active(act_o[2]));

    assign pr[0] = u0.trojan_shift_reg;
    assign pr[1] = u1.trojan_shift_reg;
    assign pr[2] = u2.trojan_shift_reg;

    function automatic logic [15:0] step(input logic [15:0] r);
        return (r[0]) ? ((r / 2) ^ TAPS) : (r / 2);
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, got, exp);
        end
    endtask

    // Behavioural model: run length of 111 samples, active flag, update count, LFSR value.
    logic        m_sum, m_cout;
    bit          m_act [3];
    int          m_run [3];
    int          m_dur [3];
    logic [15:0] m_r [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum  <= 1'b0;
            m_cout <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_act[k] <= 1'b0;
                m_run[k] <= 0;
                m_dur[k] <= 0;
                m_r[k]   <= SEED;
            end
        end else begin
            m_sum  <= ((int'(a) + int'(b) + int'(cin)) % 2) == 1;
            m_cout <= (int'(a) + int'(b) + int'(cin)) >= 2;
            for (int k = 0; k < 3; k++) begin
                if (m_act[k]) begin
                    if (AC[k] > 0 && m_dur[k] == AC[k]) begin
                        m_act[k] <= 1'b0;
                        m_r[k]   <= SEED;
                        m_dur[k] <= 0;
                        m_run[k] <= 0;
                    end else begin
                        m_r[k]   <= step(m_r[k]);
                        m_dur[k] <= m_dur[k] + 1;
                    end
                end else if (TL[k] > 0 && a && b && cin) begin
                    m_run[k] <= m_run[k] + 1;
                    if (m_run[k] + 1 >= TL[k]) begin
                        m_act[k] <= 1'b1;
                        m_dur[k] <= 0;
                    end
                end else begin
                    m_run[k] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("u%0d.sum", k), 16'(sum_o[k]), 16'(m_sum));
                check($sformatf("u%0d.cout", k), 16'(cout_o[k]), 16'(m_cout));
                check($sformatf("u%0d.active", k), 16'(act_o[k]), 16'(m_act[k]));
                check($sformatf("u%0d.shift_reg", k), pr[k], m_r[k]);
            end
        end
    end

    int          tg [3] = '{0, 0, 0};
    logic [15:0] prv [3];

    task automatic cycle(input logic [2:0] v);
        @(negedge clk);
        {a, b, cin} = v;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (pr[k] !== prv[k]) tg[k]++;
            prv[k] = pr[k];
        end
    endtask

    initial begin
        logic [7:0] exp_sum;
        logic [7:0] exp_cout;
        int t0, t1, t2;
        exp_sum  = 8'h96;
        exp_cout = 8'hE8;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst.sum", 16'(sum_o[0]), 16'h0);
        check("rst.cout", 16'(cout_o[0]), 16'h0);
        check("rst.active", 16'(act_o[0]), 16'h0);
        check("rst.shift_reg", pr[0], 16'hACE1);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) prv[k] = pr[k];

        // All operand combinations
        for (int v = 0; v < 8; v++) begin
            cycle(3'(v));
            check($sformatf("combo%0d.sum", v), 16'(sum_o[0]), 16'(exp_sum[v]));
            check($sformatf("combo%0d.cout", v), 16'(cout_o[0]), 16'(exp_cout[v]));
        end
        cycle(3'b000);
        check("combo.shift_reg", pr[0], 16'hACE1);

        // Broken trigger run never activates
        t0 = tg[0];
        repeat (5) cycle(3'b111);
        cycle(3'b000);
        repeat (5) cycle(3'b111);
        repeat (39) cycle(3'b000);
        check("broken.toggles", 16'(tg[0] - t0), 16'd0);
        check("broken.active", 16'(act_o[0]), 16'h0);

        // Six consecutive 111 samples activate the payload
        t1 = tg[1];
        repeat (6) cycle(3'b111);
        check("trig.active", 16'(act_o[0]), 16'h1);
        cycle(3'b010);
        check("trig.first_step", pr[0], 16'hE270);
        check("trig.sum", 16'(sum_o[0]), 16'h1);
        t0 = tg[0];
        for (int i = 0; i < 50; i++) cycle(3'(i % 8));
        check("active.toggles", 16'(tg[0] - t0), 16'd50);
        check("active.still", 16'(act_o[0]), 16'h1);
        check("dur10.toggles", 16'(tg[1] - t1), 16'd11);
        check("dur10.idle", 16'(act_o[1]), 16'h0);
        check("dur10.reload", pr[1], 16'hACE1);
        check("disabled.toggles", 16'(tg[2]), 16'd0);

        // Asynchronous reset between edges while ACTIVE
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.active", 16'(act_o[0]), 16'h0);
        check("arst.sum", 16'(sum_o[0]), 16'h0);
        check("arst.cout", 16'(cout_o[0]), 16'h0);
        check("arst.shift_reg", pr[0], 16'hACE1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) prv[k] = pr[k];

        // Long 111 stream: bounded payload ends, disabled payload never starts
        t1 = tg[1];
        t2 = tg[2];
        repeat (20) cycle(3'b111);
        check("dur10b.toggles", 16'(tg[1] - t1), 16'd11);
        check("dur10b.active", 16'(act_o[1]), 16'h0);
        check("dis20.active", 16'(act_o[2]), 16'h0);
        check("dis20.toggles", 16'(tg[2] - t2), 16'd0);
        check("dis20.shift_reg", pr[2], 16'hACE1);
        repeat (3) cycle(3'b000);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
